// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths, FSM encoding and line metadata for cache_sa_wb
package cache_pkg;
   // Wide enough for any address split; users keep only the low TAG_W bits.
   localparam int TAG_MAX_W = 32;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WB   = 2'd1;
   localparam logic [1:0] RF   = 2'd2;

   typedef struct packed {
      logic                 valid;
      logic                 dirty;
      logic [TAG_MAX_W-1:0] tag;
   } line_meta_t;

   function automatic int off_w(input int line_words);
      return $clog2(line_words);
   endfunction

   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_w(input int addr_w, input int line_words, input int sets);
      return addr_w - 2 - $clog2(line_words) - $clog2(sets);
   endfunction

   function automatic int way_w(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction
endpackage

// File: rtl/cache_lru.sv
// rtl/cache_lru.sv - per-set replacement state and victim selection for cache_sa_wb
// Each set keeps three tree bits; two ways use bit 0 only. Bits point at the LRU side.
module cache_lru
   import cache_pkg::*;
#(
   parameter  int SETS  = 8,
   parameter  int WAYS  = 2,
   localparam int IDX_W = idx_w(SETS),
   localparam int WAY_W = way_w(WAYS)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [IDX_W-1:0] idx,
   input  logic [WAY_W-1:0] hit_way,
   input  logic             upd,
   input  logic [WAYS-1:0]  valid_vec,
   output logic [WAY_W-1:0] victim
);
   logic [2:0] plru [SETS];
   logic [2:0] cur, nxt;
   logic [1:0] lru_way, h;

   assign cur = plru[idx];
   assign h   = 2'(hit_way);

   always_comb begin
      lru_way = '0;
      if (WAYS == 4)
         lru_way = {cur[0], cur[0] ? cur[2] : cur[1]};
      else if (WAYS == 2)
         lru_way = {1'b0, cur[0]};
      victim = lru_way[WAY_W-1:0];
      // An empty way always wins over the LRU choice, lowest index first.
      for (int w = WAYS - 1; w >= 0; w--)
         if (!valid_vec[w])
            victim = WAY_W'(w);
   end

   always_comb begin
      nxt = cur;
      if (WAYS == 4) begin
         nxt[0] = ~h[1];
         if (h[1])
            nxt[2] = ~h[0];
         else
            nxt[1] = ~h[0];
      end else begin
         nxt[0] = ~h[0];
      end
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         for (int s = 0; s < SETS; s++)
            plru[s] <= '0;
      end else if (upd) begin
         plru[idx] <= nxt;
      end
   end
endmodule

// File: rtl/cache_sa_wb.sv
// rtl/cache_sa_wb.sv - set-associative write-back write-allocate data cache
// Hits answer combinationally; a miss runs an optional writeback burst then a refill burst.
module cache_sa_wb
   import cache_pkg::*;
#(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = 4,
   parameter int SETS       = 8,
   parameter int WAYS       = 2
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req,
   input  logic              WEN,
   input  logic [ADDR_W-1:0] ADDR,
   input  logic [DATA_W-1:0] DI,
   output logic [DATA_W-1:0] DOUT,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);
   localparam int OFF_W = off_w(LINE_WORDS);
   localparam int IDX_W = idx_w(SETS);
   localparam int TAG_W = tag_w(ADDR_W, LINE_WORDS, SETS);
   localparam int WAY_W = way_w(WAYS);
   localparam logic [OFF_W-1:0] LAST = OFF_W'(LINE_WORDS - 1);

   line_meta_t        meta [WAYS][SETS];
   logic [DATA_W-1:0] data [WAYS][SETS][LINE_WORDS];

   logic [1:0]       state;
   logic [OFF_W-1:0] cnt, cnt_nxt, off;
   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag, victim_tag, evict_tag;
   logic [WAYS-1:0]  valid_vec, hit_vec;
   logic [WAY_W-1:0] hit_way, victim, victim_q;
   logic             hit, hit_upd, unused_ok;

   assign off        = ADDR[OFF_W+1:2];
   assign idx        = ADDR[IDX_W+OFF_W+1:OFF_W+2];
   assign tag        = ADDR[ADDR_W-1:ADDR_W-TAG_W];
   assign cnt_nxt    = cnt + OFF_W'(1);
   assign victim_tag = meta[victim][idx].tag[TAG_W-1:0];
   assign evict_tag  = meta[victim_q][idx].tag[TAG_W-1:0];
   assign unused_ok  = ^{ADDR[1:0], meta[0][0].tag};

   always_comb begin
      valid_vec = '0;
      hit_vec   = '0;
      hit_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         valid_vec[w] = meta[w][idx].valid;
         hit_vec[w]   = meta[w][idx].valid && (meta[w][idx].tag[TAG_W-1:0] == tag);
         if (hit_vec[w])
            hit_way = WAY_W'(w);
      end
   end

   assign hit     = |hit_vec;
   assign hit_upd = !rstn && (state == IDLE) && req && hit;
   assign stall   = !rstn && ((state != IDLE) || (req && !hit));
   assign DOUT    = hit_upd ? data[hit_way][idx][off] : '0;

   cache_lru #(.SETS(SETS), .WAYS(WAYS)) u_lru (
      .clk       (clk),
      .rstn      (rstn),
      .idx       (idx),
      .hit_way   (hit_way),
      .upd       (hit_upd),
      .valid_vec (valid_vec),
      .victim    (victim)
   );

   always_ff @(posedge clk) begin
      if (rstn) begin
         state     <= IDLE;
         cnt       <= '0;
         victim_q  <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++)
               meta[w][s] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (hit_upd && !WEN) begin
                  meta[hit_way][idx].dirty <= 1'b1;
               end else if (req && !hit) begin
                  victim_q <= victim;
                  cnt      <= '0;
                  mem_req  <= 1'b1;
                  if (meta[victim][idx].valid && meta[victim][idx].dirty) begin
                     state     <= WB;
                     mem_we    <= 1'b1;
                     mem_addr  <= {victim_tag, idx, OFF_W'(0), 2'b00};
                     mem_wdata <= data[victim][idx][0];
                  end else begin
                     state    <= RF;
                     mem_we   <= 1'b0;
                     mem_addr <= {tag, idx, OFF_W'(0), 2'b00};
                  end
               end
            end
            WB: if (mem_ack) begin
               if (cnt == LAST) begin
                  cnt      <= '0;
                  state    <= RF;
                  mem_we   <= 1'b0;
                  mem_addr <= {tag, idx, OFF_W'(0), 2'b00};
               end else begin
                  cnt       <= cnt_nxt;
                  mem_addr  <= {evict_tag, idx, cnt_nxt, 2'b00};
                  mem_wdata <= data[victim_q][idx][cnt_nxt];
               end
            end
            RF: if (mem_ack) begin
               if (cnt == LAST) begin
                  cnt     <= '0;
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  meta[victim_q][idx] <= '{valid: 1'b1, dirty: 1'b0, tag: TAG_MAX_W'(tag)};
               end else begin
                  cnt      <= cnt_nxt;
                  mem_addr <= {tag, idx, cnt_nxt, 2'b00};
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Line data is never reset; validity alone decides what may hit.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         if (hit_upd && !WEN)
            data[hit_way][idx][off] <= DI;
         else if ((state == RF) && mem_ack)
            data[victim_q][idx][cnt] <= mem_rdata;
      end
   end
endmodule

// File: tb/tb_cache_sa_wb.sv
// tb/tb_cache_sa_wb.sv - self-checking bench for cache_sa_wb against a flat-memory LRU model
module tb_cache_sa_wb;
   localparam int WAYS = 2;

   logic        clk = 1'b0;
   logic        rstn, req, WEN;
   logic [11:0] ADDR;
   logic [31:0] DI, DOUT;
   logic        stall, mem_req, mem_we;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_ack = 1'b0;

   cache_sa_wb dut (
      .clk(clk), .rstn(rstn), .req(req), .WEN(WEN), .ADDR(ADDR), .DI(DI), .DOUT(DOUT),
      .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          we;
      int          addr;
      logic [31:0] wdata;
   } xfer_t;

   int          checks = 0;
   int          errors = 0;
   int          ack_delay = 0;
   xfer_t       mlog[$];
   logic [31:0] mem_img [int];
   logic [31:0] ref_mem [int];
   int          lru_q [8][$];
   bit          dirty_m [int];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_read(input int a);
      return mem_img.exists(a) ? mem_img[a] : (32'(a) ^ 32'hA5A5A5A5);
   endfunction

   function automatic logic [31:0] ref_read(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : mem_read(a);
   endfunction

   // Memory responder: acks after ack_delay idle cycles and checks request stability while waiting.
   int          wait_cnt = 0;
   bit          have_prev = 0;
   logic [11:0] prev_addr = 12'h0;
   logic        prev_we = 1'b0;
   logic [31:0] prev_wdata = 32'h0;
   always @(negedge clk) begin
      if (rstn || !mem_req) begin
         mem_ack   = 1'b0;
         wait_cnt  = 0;
         have_prev = 0;
      end else begin
         if (have_prev) begin
            check("hold_addr", 32'(mem_addr), 32'(prev_addr));
            check("hold_we", 32'(mem_we), 32'(prev_we));
            check("hold_wdata", mem_wdata, prev_wdata);
            check("hold_stall", 32'(stall), 32'd1);
         end
         if (wait_cnt >= ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_read(int'(mem_addr));
            mlog.push_back('{mem_we, int'(mem_addr), mem_wdata});
            if (mem_we)
               mem_img[int'(mem_addr)] = mem_wdata;
            wait_cnt  = 0;
            have_prev = 0;
         end else begin
            mem_ack    = 1'b0;
            wait_cnt++;
            have_prev  = 1;
            prev_addr  = mem_addr;
            prev_we    = mem_we;
            prev_wdata = mem_wdata;
         end
      end
   end

   // Every completed read must return the latest value the core wrote (or memory's initial value).
   always @(negedge clk) begin
      if (!rstn) begin
         if (req && WEN && !stall)
            check("dout_model", DOUT, ref_read(int'(ADDR) & 'hFFC));
         if (!req)
            check("idle_stall", 32'(stall), 32'd0);
      end
   end

   task automatic model_reset();
      for (int s = 0; s < 8; s++)
         lru_q[s].delete();
      dirty_m.delete();
      ref_mem.delete();
   endtask

   task automatic access(input bit is_write, input logic [11:0] a, input logic [31:0] d,
                         output logic [31:0] dout_seen, output int cycles);
      xfer_t exp_q[$];
      int    s, line, pos, start, exp_cycles, ev;
      s    = (int'(a) >> 4) & 7;
      line = int'(a) & 'hFF0;
      pos  = -1;
      for (int i = 0; i < lru_q[s].size(); i++)
         if (lru_q[s][i] == line)
            pos = i;
      if (pos >= 0) begin
         lru_q[s].delete(pos);
      end else begin
         if (lru_q[s].size() == WAYS) begin
            ev = lru_q[s].pop_front();
            if (dirty_m.exists(ev) && dirty_m[ev])
               for (int k = 0; k < 4; k++)
                  exp_q.push_back('{1'b1, ev + 4*k, ref_read(ev + 4*k)});
            dirty_m[ev] = 0;
         end
         for (int k = 0; k < 4; k++)
            exp_q.push_back('{1'b0, line + 4*k, 32'h0});
      end
      lru_q[s].push_back(line);
      if (is_write)
         dirty_m[line] = 1;
      exp_cycles = (pos >= 0) ? 0 : 1 + exp_q.size() * (ack_delay + 1);

      start = mlog.size();
      req   = 1'b1;
      WEN   = !is_write;
      ADDR  = a;
      DI    = d;
      cycles = 0;
      forever begin
         @(negedge clk);
         if (!stall)
            break;
         cycles++;
         if (cycles > 500) begin
            check("stall_timeout", 32'(cycles), 32'(exp_cycles));
            break;
         end
      end
      dout_seen = DOUT;
      @(posedge clk);
      if (is_write)
         ref_mem[int'(a) & 'hFFC] = d;
      #1 req = 1'b0;

      check("stall_cycles", 32'(cycles), 32'(exp_cycles));
      check("xfer_count", 32'(mlog.size() - start), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && start + i < mlog.size(); i++) begin
         check("xfer_we", 32'(mlog[start+i].we), 32'(exp_q[i].we));
         check("xfer_addr", 32'(mlog[start+i].addr), 32'(exp_q[i].addr));
         if (exp_q[i].we)
            check("xfer_wdata", mlog[start+i].wdata, exp_q[i].wdata);
      end
   endtask

   initial begin
      logic [31:0] dv;
      int          cyc, start, waited;
      rstn = 1'b1; req = 1'b0; WEN = 1'b1; ADDR = '0; DI = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_dout", DOUT, 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      @(posedge clk);
      #1 rstn = 1'b0;

      access(0, 12'h010, 32'h0, dv, cyc);
      check("rd010_dout", dv, 32'hA5A5A5B5);
      check("rd010_cycles", 32'(cyc), 32'd5);
      access(0, 12'h014, 32'h0, dv, cyc);
      check("rd014_dout", dv, 32'hA5A5A5B1);
      check("rd014_cycles", 32'(cyc), 32'd0);

      access(1, 12'h020, 32'hDEADBEEF, dv, cyc);
      access(0, 12'h020, 32'h0, dv, cyc);
      check("rd020_dout", dv, 32'hDEADBEEF);
      check("rd020_cycles", 32'(cyc), 32'd0);

      access(0, 12'h000, 32'h0, dv, cyc);
      access(0, 12'h080, 32'h0, dv, cyc);
      access(0, 12'h000, 32'h0, dv, cyc);
      check("touch000_cycles", 32'(cyc), 32'd0);
      access(0, 12'h100, 32'h0, dv, cyc);
      check("rd100_clean_evict", 32'(cyc), 32'd5);

      access(1, 12'h084, 32'h12345678, dv, cyc);
      access(0, 12'h100, 32'h0, dv, cyc);
      start = mlog.size();
      access(0, 12'h180, 32'h0, dv, cyc);
      check("rd180_dirty_evict", 32'(cyc), 32'd9);
      if (mlog.size() > start + 1) begin
         check("wb084_addr", 32'(mlog[start+1].addr), 32'h084);
         check("wb084_data", mlog[start+1].wdata, 32'h12345678);
      end else begin
         check("wb084_present", 32'(mlog.size() - start), 32'd8);
      end
      access(0, 12'h084, 32'h0, dv, cyc);
      check("rd084_after_wb", dv, 32'h12345678);

      ack_delay = 3;
      access(0, 12'h200, 32'h0, dv, cyc);
      check("rd200_slow_cycles", 32'(cyc), 32'd17);
      check("rd200_slow_dout", dv, 32'hA5A5A7A5);
      access(1, 12'h204, 32'hCAFEF00D, dv, cyc);
      access(0, 12'h080, 32'h0, dv, cyc);
      access(0, 12'h300, 32'h0, dv, cyc);
      check("rd300_slow_wb_cycles", 32'(cyc), 32'd33);
      access(0, 12'h204, 32'h0, dv, cyc);
      check("rd204_after_slow_wb", dv, 32'hCAFEF00D);
      ack_delay = 0;

      start = mlog.size();
      req = 1'b1; WEN = 1'b1; ADDR = 12'h030;
      waited = 0;
      while (mlog.size() <= start && waited < 100) begin
         @(negedge clk);
         #1 waited++;
      end
      check("mid_first_ack", 32'(mlog.size() > start), 32'd1);
      @(posedge clk);
      #1 rstn = 1'b1; req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_mem_req", 32'(mem_req), 32'd0);
      check("abort_stall", 32'(stall), 32'd0);
      @(posedge clk);
      #1 rstn = 1'b0;
      model_reset();
      access(0, 12'h030, 32'h0, dv, cyc);
      check("rd030_refill_cycles", 32'(cyc), 32'd5);
      check("rd030_dout", dv, 32'hA5A5A595);
      access(0, 12'h010, 32'h0, dv, cyc);
      check("rd010_post_reset", 32'(cyc), 32'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cache_sa_wb.md
Name: cache_sa_wb

Overview:
- Parametrised set-associative, write-back, write-allocate data cache between the core's data port and the word-wide memory port.
- Successor to the direct-mapped write-through lab cache. Adds N-way associativity, LRU replacement, dirty-line eviction, and a handshaked multi-word refill/writeback burst.
- Core side keeps the same ADDR/DI/DOUT/WEN/stall contract.

Parameters:
- ADDR_W, 12: byte address width.
- DATA_W, 32: word width.
- LINE_WORDS, 4: words per line (power of 2).
- SETS, 8: number of sets (power of 2).
- WAYS, 2: associativity (1, 2 or 4).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rstn  in  1  synchronous reset, active-high (asserted = 1), sampled on posedge clk.
- req  in  1  core access request; ADDR/DI/WEN held stable while stall=1.
- WEN  in  1  0 = write, 1 = read.
- ADDR  in  ADDR_W  byte address; bits [1:0] ignored.
- DI  in  DATA_W  write data.
- DOUT  out  DATA_W  read data, valid when req=1, WEN=1, stall=0.
- stall  out  1  1 = core must hold the request.
- mem_req  out  1  memory word transfer request.
- mem_we  out  1  1 = memory write.
- mem_addr  out  ADDR_W  word-aligned memory byte address.
- mem_wdata  out  DATA_W  writeback data.
- mem_rdata  in  DATA_W  refill data, valid with mem_ack.
- mem_ack  in  1  transfer accepted/completed this cycle.

Behaviour:
- Address split: off = ADDR[log2(LINE_WORDS)+1:2], idx = next log2(SETS) bits, tag = remaining upper bits. Defaults: off [3:2], idx [6:4], tag [11:7].
- Per line state: valid, dirty, tag, LINE_WORDS data words. Per set: LRU state (1 bit for WAYS=2; tree pseudo-LRU for WAYS=4).
- Reset (rstn=1 at posedge):
  - All valid, dirty and LRU bits cleared; data arrays need not clear.
  - FSM to IDLE; word counter 0.
  - Outputs: stall=0, DOUT=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset mid-burst aborts immediately. mem_req is 0 the cycle after. A partially refilled line stays invalid.
- Hit (IDLE, req=1, tag match on a valid way):
  - stall=0 combinationally in the same cycle; DOUT = matching word combinationally.
  - A write updates the word and sets dirty at the edge.
  - LRU is updated to mark the hit way most recent.
  - 0 wait states.
- Miss (IDLE, req=1, no match):
  - stall=1 in the same cycle.
  - Victim = first invalid way (lowest index); otherwise the LRU way.
  - Victim valid and dirty -> WB, else -> RF.
- WB:
  - mem_req=1, mem_we=1, mem_addr={victim tag, idx, cnt, 2'b00}, mem_wdata = victim word cnt.
  - On mem_ack, cnt increments.
  - When cnt = LINE_WORDS-1 and mem_ack=1: cnt to 0, go to RF.
- RF:
  - mem_req=1, mem_we=0, mem_addr={req tag, idx, cnt, 2'b00}.
  - On mem_ack, mem_rdata is written into victim word cnt.
  - On the last word: set tag, valid=1, dirty=0; go to IDLE.
  - The next cycle is a hit, so total miss penalty = words transferred + 1.
- mem_req/mem_we/mem_addr are registered outputs and stay stable until mem_ack. mem_ack while mem_req=0 is ignored.
- req=0 in IDLE: stall=0, no state change. Dropping req during WB/RF is illegal; the burst completes regardless.
- A write miss allocates (refill), then performs the write as a hit.
- cnt wraps modulo LINE_WORDS. Addresses are formed by concatenation, with no arithmetic carry into idx.

Decomposition:
- Package cache_pkg:
  - Derived widths OFF_W, IDX_W, TAG_W as functions of the parameters.
  - FSM state enum {IDLE, WB, RF}.
  - Line-metadata struct {valid, dirty, tag}.
- One sub-module: cache_lru (per-set LRU storage and victim select).
  - Inputs: idx, hit way, update enable, valid vector.
  - Output: victim way.

Test Plan:
- Reset, then read 0x010 with memory word at byte address A = A^0xA5A5A5A5 -> stall high for 4 acks + 1 cycle; DOUT=0xA5A5A5B5; subsequent read 0x014 returns 0xA5A5A5B1 with stall=0.
- Write 0x020 DI=0xDEADBEEF (hit after fill), read back -> 0xDEADBEEF, no memory traffic.
- Fill both ways of set 0 (0x000, 0x080), touch 0x000, then read 0x100 -> victim is the 0x080 way, clean, so RF only (4 mem transactions).
- Dirty 0x084 with 0x12345678, then force eviction of that way -> 4 writes at 0x080..0x08C with 0x12345678 at 0x084, then 4 refill reads.
- mem_ack delayed 3 cycles per word -> mem_addr/mem_req stay stable, stall held, result data correct.
- Assert rstn during the second refill word -> next cycle mem_req=0, stall=0; re-read of the same address misses and refills all 4 words.
